// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART defaults used by the transmit/receive datapath blocks
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_BAUD_RATE  = 115200;
  localparam int UART_CLK_FREQ   = 100_000_000;
  localparam int UART_FIFO_DEPTH = 16;

endpackage

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// ============================================================================
// uart_fifo_mem : register array, one write port, one asynchronous read port
// Revision      : 1.0
// ============================================================================
`default_nettype none

module uart_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  // Storage is deliberately left without reset so it maps onto plain flops/LUTRAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo : first-word-fall-through elastic buffer ahead of the UART TX
// Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = UART_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clear,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int             AW         = $clog2(DEPTH);
  localparam int             CW         = AW + 1;
  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  push;
  logic                  pop;

  // Handshakes depend only on registered occupancy, so a pop never frees a
  // slot for a push in the same cycle.
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready && !clear;
  assign pop       = out_valid && out_ready && !clear;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  // Storage is unreset, so mask the read port while nothing valid is held.
  assign out_data = empty ? '0 : rd_word;

  a_count_range : assert property (@(posedge clk) disable iff (!rstn) count <= FULL_COUNT);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// tb_uart_tx_fifo : scoreboard bench for uart_tx_fifo with DEPTH=4
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          clear;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    count;
  logic          full;
  logic          empty;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] sb[$];

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are sampled mid-cycle, where inputs and registered outputs are stable.
  always @(negedge clk) begin
    logic [DW-1:0] exp;
    if (!rstn || clear) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        check("pop_data", 32'(out_data), 32'(exp));
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
      end
    end
  end

  task automatic fill(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_data  = base + DW'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) tick();
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    rstn = 1'b1;
    tick();

    // single word, one-cycle latency
    fill(8'hA5, 1);
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_out_data", 32'(out_data), 32'hA5);
    check("t1_count", 32'(count), 1);
    check("t1_empty", 32'(empty), 0);
    drain(1);
    check("t1_empty_after", 32'(empty), 1);
    check("t1_count_after", 32'(count), 0);

    // fill to full, fifth word held off
    fill(8'h01, 4);
    check("t2_full", 32'(full), 1);
    check("t2_in_ready", 32'(in_ready), 0);
    check("t2_count", 32'(count), 4);
    in_data = 8'h05; in_valid = 1'b1;
    tick();
    check("t2_held_count", 32'(count), 4);
    out_ready = 1'b1;
    tick();
    check("t2_pop_no_push", 32'(count), 3);
    tick();
    in_valid = 1'b0;
    check("t2_push_and_pop", 32'(count), 3);
    tick(); tick(); tick();
    out_ready = 1'b0;
    check("t2_drained", 32'(count), 0);

    // streaming at count=2 with pointer wrap
    fill(8'h0E, 2);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'h10 + DW'(i);
      tick();
      check("t3_stream_count", 32'(count), 2);
    end
    in_valid = 1'b0;
    drain(2);
    check("t3_drained", 32'(empty), 1);

    // full with simultaneous push and pop
    fill(8'h40, 4);
    in_data = 8'h44; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("t4_pop_only", 32'(count), 3);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("t4_push_next", 32'(count), 4);
    check("t4_full", 32'(full), 1);
    drain(4);
    check("t4_drained", 32'(count), 0);

    // clear wins over push and pop
    fill(8'h50, 3);
    check("t5_pre_count", 32'(count), 3);
    clear = 1'b1; in_data = 8'h77; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("t5_count", 32'(count), 0);
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_in_ready", 32'(in_ready), 1);
    fill(8'h88, 1);
    check("t5_first_out", 32'(out_data), 32'h88);
    drain(1);

    // asynchronous reset mid-cycle
    fill(8'h60, 2);
    check("t6_pre_count", 32'(count), 2);
    #2 rstn = 1'b0;
    #1;
    check("t6_async_count", 32'(count), 0);
    check("t6_async_empty", 32'(empty), 1);
    check("t6_async_out_valid", 32'(out_valid), 0);
    check("t6_async_out_data", 32'(out_data), 0);
    check("t6_async_in_ready", 32'(in_ready), 1);
    tick();
    rstn = 1'b1;
    tick();
    fill(8'h3C, 1);
    check("t6_first_valid", 32'(out_valid), 1);
    check("t6_first_out", 32'(out_data), 32'h3C);
    drain(1);
    check("t6_drained", 32'(empty), 1);

    check("sb_leftover", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
